// File: rtl/msi_l1_cache.sv
// Direct-mapped, one-word-per-line L1 cache with MSI coherence on a shared bus.
// A core-side FSM handles hits, misses and upgrades; snoops are serviced every cycle.
module msi_l1_cache #(
   parameter int LINES = 8,
   parameter int AW    = 9
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          mem_valid,
   input  logic          mem_instr,
   input  logic [AW-1:0] mem_addr,
   input  logic [31:0]   mem_wdata,
   input  logic [3:0]    mem_wstrb,
   output logic          mem_ready,
   output logic [31:0]   mem_rdata,
   output logic          bus_req,
   output logic [1:0]    bus_cmd,
   output logic [AW-1:0] bus_addr,
   output logic [31:0]   bus_wdata,
   input  logic          bus_ack,
   input  logic [31:0]   bus_rdata,
   input  logic          snoop_valid,
   input  logic [1:0]    snoop_cmd,
   input  logic [AW-1:0] snoop_addr,
   output logic          snoop_flush,
   output logic [31:0]   snoop_data
);
   localparam int IW = $clog2(LINES);
   localparam int TW = AW - 2 - IW;

   localparam logic [1:0] CMD_FLUSH = 2'b00;
   localparam logic [1:0] CMD_RD    = 2'b01;
   localparam logic [1:0] CMD_RDX   = 2'b10;
   localparam logic [1:0] CMD_UPGR  = 2'b11;

   typedef enum logic [1:0] {L_I, L_S, L_M} line_st_t;
   typedef enum logic [2:0] {IDLE, WB, FILL, UPGR, RESP} fsm_t;

   fsm_t             state_q, state_d;
   line_st_t         st_q  [LINES];
   line_st_t         st_snp[LINES];
   logic [TW-1:0]    tag_q [LINES];
   logic [31:0]      data_q[LINES];

   logic [IW-1:0]    idx, s_idx;
   logic [TW-1:0]    tag, s_tag;
   logic             is_wr, line_hit, ack, s_hit, snp_flush_d;
   logic [3:0]       wr_strb;

   logic             breq_d;
   logic [1:0]       cmd_d;
   logic [AW-1:0]    addr_d;
   logic [31:0]      wdata_d;

   logic             upd_st_en, upd_tag_en, upd_data_en;
   line_st_t         upd_st;
   logic [31:0]      upd_data;

   wire unused_addr_lsbs = &{1'b0, mem_addr[1:0], snoop_addr[1:0]};

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] strb);
      logic [31:0] r;
      for (int b = 0; b < 4; b++)
         r[8*b +: 8] = strb[b] ? wd[8*b +: 8] : old[8*b +: 8];
      return r;
   endfunction

   assign idx      = mem_addr[IW+1:2];
   assign tag      = mem_addr[AW-1:IW+2];
   assign s_idx    = snoop_addr[IW+1:2];
   assign s_tag    = snoop_addr[AW-1:IW+2];
   // Instruction fetches never write, whatever the strobes say.
   assign is_wr    = (mem_wstrb != 4'b0000) && !mem_instr;
   assign wr_strb  = is_wr ? mem_wstrb : 4'b0000;
   assign ack      = bus_req && bus_ack;
   assign s_hit    = snoop_valid && (st_q[s_idx] != L_I) && (tag_q[s_idx] == s_tag);
   // Hit decisions see the post-snoop state so a same-cycle invalidate wins.
   assign line_hit = (st_snp[idx] != L_I) && (tag_q[idx] == tag);

   assign mem_ready = (state_q == RESP);
   assign mem_rdata = (state_q == RESP) ? data_q[idx] : 32'h0;

   always_comb begin
      st_snp      = st_q;
      snp_flush_d = 1'b0;
      if (s_hit) begin
         case (snoop_cmd)
            CMD_RD: if (st_q[s_idx] == L_M) begin
               snp_flush_d   = 1'b1;
               st_snp[s_idx] = L_S;
            end
            CMD_RDX: begin
               snp_flush_d   = (st_q[s_idx] == L_M);
               st_snp[s_idx] = L_I;
            end
            CMD_UPGR: if (st_q[s_idx] == L_S) st_snp[s_idx] = L_I;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      breq_d      = bus_req;
      cmd_d       = bus_cmd;
      addr_d      = bus_addr;
      wdata_d     = bus_wdata;
      upd_st_en   = 1'b0;
      upd_st      = L_I;
      upd_tag_en  = 1'b0;
      upd_data_en = 1'b0;
      upd_data    = 32'h0;
      case (state_q)
         IDLE: if (mem_valid && !mem_ready) begin
            if (line_hit) begin
               if (!is_wr) state_d = RESP;
               else if (st_snp[idx] == L_M) begin
                  upd_data_en = 1'b1;
                  upd_data    = merge(data_q[idx], mem_wdata, wr_strb);
                  state_d     = RESP;
               end else state_d = UPGR;
            end else if (st_snp[idx] == L_M) state_d = WB;
            else state_d = FILL;
         end
         WB: begin
            if (ack) begin
               upd_st_en = 1'b1;
               upd_st    = L_I;
               breq_d    = 1'b0;
               cmd_d     = 2'b00;
               addr_d    = '0;
               wdata_d   = 32'h0;
               state_d   = FILL;
            end else if (!bus_req) begin
               // Victim lost M to a snoop before we asked: nothing left to write back.
               if (st_snp[idx] != L_M) state_d = FILL;
               else begin
                  breq_d  = 1'b1;
                  cmd_d   = CMD_FLUSH;
                  addr_d  = {tag_q[idx], idx, 2'b00};
                  wdata_d = data_q[idx];
               end
            end
         end
         FILL: begin
            if (ack) begin
               upd_st_en   = 1'b1;
               upd_st      = is_wr ? L_M : L_S;
               upd_tag_en  = 1'b1;
               upd_data_en = 1'b1;
               upd_data    = merge(bus_rdata, mem_wdata, wr_strb);
               breq_d      = 1'b0;
               cmd_d       = 2'b00;
               addr_d      = '0;
               wdata_d     = 32'h0;
               state_d     = RESP;
            end else if (!bus_req) begin
               breq_d  = 1'b1;
               cmd_d   = is_wr ? CMD_RDX : CMD_RD;
               addr_d  = {tag, idx, 2'b00};
               wdata_d = 32'h0;
            end
         end
         UPGR: begin
            // Lost the S copy: withdraw the upgrade and refetch with ownership.
            if (!(line_hit && st_snp[idx] == L_S)) begin
               breq_d  = 1'b0;
               cmd_d   = 2'b00;
               addr_d  = '0;
               wdata_d = 32'h0;
               state_d = FILL;
            end else if (ack) begin
               upd_st_en   = 1'b1;
               upd_st      = L_M;
               upd_data_en = 1'b1;
               upd_data    = merge(data_q[idx], mem_wdata, wr_strb);
               breq_d      = 1'b0;
               cmd_d       = 2'b00;
               addr_d      = '0;
               wdata_d     = 32'h0;
               state_d     = RESP;
            end else if (!bus_req) begin
               breq_d  = 1'b1;
               cmd_d   = CMD_UPGR;
               addr_d  = {tag, idx, 2'b00};
               wdata_d = 32'h0;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         bus_req     <= 1'b0;
         bus_cmd     <= 2'b00;
         bus_addr    <= '0;
         bus_wdata   <= 32'h0;
         snoop_flush <= 1'b0;
         snoop_data  <= 32'h0;
         for (int i = 0; i < LINES; i++) st_q[i] <= L_I;
      end else begin
         state_q     <= state_d;
         bus_req     <= breq_d;
         bus_cmd     <= cmd_d;
         bus_addr    <= addr_d;
         bus_wdata   <= wdata_d;
         snoop_flush <= snp_flush_d;
         snoop_data  <= snp_flush_d ? data_q[s_idx] : 32'h0;
         // Snoop effect first, local update overrides on the same line.
         for (int i = 0; i < LINES; i++) st_q[i] <= st_snp[i];
         if (upd_st_en) st_q[idx] <= upd_st;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (upd_tag_en)  tag_q[idx]  <= tag;
         if (upd_data_en) data_q[idx] <= upd_data;
      end
   end

endmodule

// File: tb/tb_msi_l1_cache.sv
// Directed bench for msi_l1_cache: hit/miss, upgrade, write-back, snoops,
// upgrade-vs-invalidate race and mid-transaction reset.
module tb_msi_l1_cache;
   logic        clk = 1'b0;
   logic        reset;
   logic        mem_valid, mem_instr;
   logic [8:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        bus_req;
   logic [1:0]  bus_cmd;
   logic [8:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        snoop_valid;
   logic [1:0]  snoop_cmd;
   logic [8:0]  snoop_addr;
   logic        snoop_flush;
   logic [31:0] snoop_data;

   int n_chk = 0;
   int n_err = 0;

   msi_l1_cache #(.LINES(8), .AW(9)) dut (
      .clk(clk), .reset(reset),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .bus_req(bus_req), .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd), .snoop_addr(snoop_addr),
      .snoop_flush(snoop_flush), .snoop_data(snoop_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) until bus_req is seen at a negedge.
   task automatic wait_req();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus_req && n < 40);
      if (!bus_req) chk("bus_req_timeout", 32'(bus_req), 32'd1);
   endtask

   task automatic start(input logic [8:0] a, input logic [31:0] wd, input logic [3:0] strb,
                        input logic instr);
      mem_valid = 1'b1;
      mem_addr  = a;
      mem_wdata = wd;
      mem_wstrb = strb;
      mem_instr = instr;
   endtask

   // Pulse bus_ack for one cycle; returns at the negedge following the ack edge.
   task automatic do_ack(input logic [31:0] d);
      bus_ack   = 1'b1;
      bus_rdata = d;
      @(negedge clk);
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
   endtask

   task automatic finish_req();
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
      mem_instr = 1'b0;
      @(negedge clk);
      chk("ready_one_cycle", 32'(mem_ready), 32'd0);
   endtask

   task automatic snoop(input logic [1:0] c, input logic [8:0] a);
      snoop_valid = 1'b1;
      snoop_cmd   = c;
      snoop_addr  = a;
      @(negedge clk);
      snoop_valid = 1'b0;
      snoop_cmd   = 2'b00;
      snoop_addr  = 9'h0;
   endtask

   initial begin
      reset = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = 9'h0;
      mem_wdata = 32'h0; mem_wstrb = 4'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
      snoop_valid = 1'b0; snoop_cmd = 2'b00; snoop_addr = 9'h0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(mem_ready), 32'd0);
      chk("rst_bus_req", 32'(bus_req), 32'd0);
      chk("rst_snoop_flush", 32'(snoop_flush), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Cold read miss, then hit
      start(9'h004, 32'h0, 4'h0, 1'b0);
      wait_req();
      chk("rd_miss_cmd", 32'(bus_cmd), 32'd1);
      chk("rd_miss_addr", 32'(bus_addr), 32'h004);
      do_ack(32'hDEADBEEF);
      chk("rd_miss_ready", 32'(mem_ready), 32'd1);
      chk("rd_miss_data", mem_rdata, 32'hDEADBEEF);
      chk("rd_miss_req_drop", 32'(bus_req), 32'd0);
      finish_req();

      start(9'h004, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      chk("rd_hit_ready", 32'(mem_ready), 32'd1);
      chk("rd_hit_data", mem_rdata, 32'hDEADBEEF);
      chk("rd_hit_no_req", 32'(bus_req), 32'd0);
      finish_req();

      // Fetch with strobes set is a plain read
      start(9'h004, 32'hFFFFFFFF, 4'hF, 1'b1);
      @(negedge clk);
      chk("ifetch_ready", 32'(mem_ready), 32'd1);
      chk("ifetch_data", mem_rdata, 32'hDEADBEEF);
      chk("ifetch_no_req", 32'(bus_req), 32'd0);
      finish_req();

      // Write hit on S -> BusUpgr
      start(9'h004, 32'h11223344, 4'b0011, 1'b0);
      wait_req();
      chk("upgr_cmd", 32'(bus_cmd), 32'd3);
      chk("upgr_addr", 32'(bus_addr), 32'h004);
      do_ack(32'h0);
      chk("upgr_ready", 32'(mem_ready), 32'd1);
      chk("upgr_data", mem_rdata, 32'hDEAD3344);
      finish_req();

      // Conflict miss with dirty victim -> Flush then BusRd
      start(9'h024, 32'h0, 4'h0, 1'b0);
      wait_req();
      chk("wb_cmd", 32'(bus_cmd), 32'd0);
      chk("wb_addr", 32'(bus_addr), 32'h004);
      chk("wb_data", bus_wdata, 32'hDEAD3344);
      do_ack(32'h0);
      chk("wb_no_ready", 32'(mem_ready), 32'd0);
      wait_req();
      chk("wb_fill_cmd", 32'(bus_cmd), 32'd1);
      chk("wb_fill_addr", 32'(bus_addr), 32'h024);
      do_ack(32'hCAFEF00D);
      chk("wb_fill_ready", 32'(mem_ready), 32'd1);
      chk("wb_fill_data", mem_rdata, 32'hCAFEF00D);
      finish_req();

      // Write miss over clean victim -> BusRdX, line M
      start(9'h004, 32'hA5A5A5A5, 4'hF, 1'b0);
      wait_req();
      chk("wr_miss_cmd", 32'(bus_cmd), 32'd2);
      chk("wr_miss_addr", 32'(bus_addr), 32'h004);
      do_ack(32'h12345678);
      chk("wr_miss_data", mem_rdata, 32'hA5A5A5A5);
      finish_req();

      // Snoops: BusRd on M flushes, BusRd on S silent, BusRdX on S silent
      snoop(2'b01, 9'h004);
      chk("snp_rd_flush", 32'(snoop_flush), 32'd1);
      chk("snp_rd_data", snoop_data, 32'hA5A5A5A5);
      @(negedge clk);
      chk("snp_flush_width", 32'(snoop_flush), 32'd0);
      snoop(2'b01, 9'h004);
      chk("snp_rd_on_s", 32'(snoop_flush), 32'd0);
      snoop(2'b10, 9'h004);
      chk("snp_rdx_on_s", 32'(snoop_flush), 32'd0);
      start(9'h004, 32'h0, 4'h0, 1'b0);
      wait_req();
      chk("after_inv_cmd", 32'(bus_cmd), 32'd1);
      do_ack(32'h0BADF00D);
      chk("after_inv_data", mem_rdata, 32'h0BADF00D);
      finish_req();

      // Upgrade lost to a BusRdX snoop -> withdrawn, BusRdX with merged write
      start(9'h004, 32'h55667788, 4'b1100, 1'b0);
      wait_req();
      chk("race_upgr_cmd", 32'(bus_cmd), 32'd3);
      snoop(2'b10, 9'h004);
      chk("race_no_flush", 32'(snoop_flush), 32'd0);
      chk("race_req_drop", 32'(bus_req), 32'd0);
      wait_req();
      chk("race_rdx_cmd", 32'(bus_cmd), 32'd2);
      chk("race_rdx_addr", 32'(bus_addr), 32'h004);
      do_ack(32'h11111111);
      chk("race_ready", 32'(mem_ready), 32'd1);
      chk("race_data", mem_rdata, 32'h55661111);
      finish_req();

      // Reset during FILL
      start(9'h008, 32'h0, 4'h0, 1'b0);
      wait_req();
      reset = 1'b1;
      mem_valid = 1'b0;
      @(negedge clk);
      chk("rst_fill_req", 32'(bus_req), 32'd0);
      chk("rst_fill_ready", 32'(mem_ready), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      start(9'h004, 32'h0, 4'h0, 1'b0);
      wait_req();
      chk("post_rst_miss_cmd", 32'(bus_cmd), 32'd1);
      chk("post_rst_miss_addr", 32'(bus_addr), 32'h004);
      do_ack(32'h77777777);
      chk("post_rst_data", mem_rdata, 32'h77777777);
      finish_req();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
